// File: rtl/div_iter_pkg.sv
// Shared divider definitions: FSM state encoding and the fixed issue-to-done latency
// the hazard unit stalls for.
package div_iter_pkg;

    localparam int DIV_WIDTH   = 32;
    // Start edge plus WIDTH restoring steps; done appears in the cycle after the last step.
    localparam int DIV_LATENCY = DIV_WIDTH + 1;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: one quotient bit per clock, sign fix-up
// and divide-by-zero handling applied when the result is registered on entry to DONE.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             div_busy,
    output logic             div_done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_t       state;
    div_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] quo_acc;
    logic [WIDTH-1:0] dvsr_mag;
    logic [WIDTH-1:0] dvd_raw;
    logic             quo_neg;
    logic             rem_neg;
    logic             div_zero;

    logic signed [WIDTH-1:0] dvd_s;
    logic signed [WIDTH-1:0] dvs_s;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    logic accept;
    logic last_step;
    logic running;

    assign dvd_s   = dividend;
    assign dvs_s   = divisor;
    assign dvd_neg = div_signed && (dvd_s < 0);
    assign dvs_neg = div_signed && (dvs_s < 0);
    // WIDTH-bit unsigned magnitudes, so the most negative operand still fits.
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor  : divisor;

    assign running   = (state == DIV_RUN);
    assign accept    = div_start && !flush && !running;
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    assign div_busy = running;
    assign div_done = (state == DIV_DONE);

    always_comb begin
        shifted  = {rem_acc, quo_acc[WIDTH-1]};
        trial    = shifted - {1'b0, dvsr_mag};
        // A borrow out of the WIDTH+1-bit trial means "restore": keep the shifted value.
        rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_step = {quo_acc[WIDTH-2:0], ~trial[WIDTH]};

        q_fix = div_zero ? '1 : (quo_neg ? -quo_step : quo_step);
        r_fix = div_zero ? dvd_raw : (rem_neg ? -rem_step : rem_step);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (div_start) state_nxt = DIV_RUN;
            DIV_RUN:  if (last_step) state_nxt = DIV_DONE;
            DIV_DONE: state_nxt = div_start ? DIV_RUN : DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
        if (flush) state_nxt = DIV_IDLE;
    end

    // Control and architecturally visible results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DIV_IDLE;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= '0;
            end else if (running && !flush) begin
                cnt <= cnt + 1'b1;
            end
            if (running && last_step && !flush) begin
                quotient  <= q_fix;
                remainder <= r_fix;
            end
        end
    end

    // Iteration datapath; only meaningful while RUN, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_acc  <= '0;
            quo_acc  <= dvd_mag;
            dvsr_mag <= dvs_mag;
            dvd_raw  <= dividend;
            quo_neg  <= dvd_neg ^ dvs_neg;
            rem_neg  <= dvd_neg;
            div_zero <= (divisor == '0);
        end else if (running) begin
            rem_acc <= rem_step;
            quo_acc <= quo_step;
        end
    end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle radix-2 restoring divider for the EXE stage, serving MIPS DIV/DIVU.
- Takes operands from the EXE forwarding muxes (post-forwarding rs/rt values).
- Produces quotient/remainder for the HI/LO write path and the EXE result-select mux.
- Drives busy to the hazard unit, which stalls the pipeline while a division is in flight.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  pipeline flush (exception/eret); cancels any operation.
- div_start  input  1  start request, sampled on the rising edge.
- div_signed  input  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  input  WIDTH  rs value.
- divisor  input  WIDTH  rt value.
- div_busy  output  1  high while iterating (state RUN).
- div_done  output  1  one-cycle pulse; results valid.
- quotient  output  WIDTH  to LO.
- remainder  output  WIDTH  to HI.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (sync, highest priority): state=IDLE, counter=0, busy=0, done=0, quotient=0, remainder=0.
- Flush (priority below rst, above start), any state: next state IDLE, done stays 0, quotient/remainder hold their previous values. Flush and start in the same cycle: start is dropped.
- IDLE or DONE, start=1: latch |dividend|, |divisor| (magnitudes only when div_signed=1, else raw), sign flags, div-by-zero flag, counter=0; next state RUN.
- IDLE, start=0: stay IDLE.
- DONE, start=0: return to IDLE.
- DONE, start=1: accepted (back-to-back division).
- RUN: one restoring step per edge (shift partial remainder left by 1, trial-subtract divisor magnitude, set quotient bit if non-negative), counter++. On the edge where counter==WIDTH-1, do the final step and go to DONE.
- div_start while in RUN is ignored; operands are not re-sampled.
- Latency: start sampled at edge 0; busy high for cycles 1..WIDTH; done high in cycle WIDTH+1 only (cycle 33 for WIDTH=32).
- quotient/remainder are registered at the transition into DONE and held stable until the next accepted start completes.
- Sign correction in signed mode:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Magnitudes are WIDTH-bit unsigned, so |-2^(WIDTH-1)| is representable.
  - 0x80000000 / -1 naturally yields q=0x80000000, r=0.
- Divide by zero (architecturally undefined; fixed here): q = all ones, r = raw dividend, no sign correction, same latency, no exception.
- All arithmetic is on WIDTH+1 bits for the trial subtraction. No combinational path from inputs to outputs.

Decomposition:
- Shared CPU package:
  - typedef enum logic [1:0] div_state_t {DIV_IDLE, DIV_RUN, DIV_DONE}.
  - Localparam DIV_LATENCY = WIDTH+1, for hazard-unit documentation and bench checks.
- No sub-module: a single always_ff FSM/datapath plus a small always_comb for next state. Sign correction is inline.

Test Plan:
- Unsigned 100 / 7, div_signed=0 -> busy cycles 1..32, done pulse in cycle 33 only; q=14, r=2.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7 / -2 -> q=0xFFFFFFFD, r=0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0. Unsigned 0xFFFFFFFF / 1 -> q=0xFFFFFFFF, r=0.
- Divide by zero: 5 / 0, either mode -> q=0xFFFFFFFF, r=5, done in cycle 33.
- Flush asserted in cycle 10 of RUN -> busy=0 from cycle 11, no done pulse. New start 20/3 in cycle 12 -> q=6, r=2 in cycle 45. Flush+start same cycle -> stays IDLE. rst mid-RUN -> all outputs 0 next cycle.
- Back-to-back: start in the DONE cycle of 9/4 (q=2, r=1) with 50/5 -> second done 33 cycles later, q=10, r=0; first results held until then. Start pulses during RUN ignored.
